if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/if_pc_unit.sv | 38 +++
 rtl/if_stage.sv | 122 ++++++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, instruction classes, IF FSM states and the IF/ID payload.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned JFW  = 26;

  localparam logic [OPW-1:0] OP_R     = 6'b000000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {ITYPE_R, ITYPE_J, ITYPE_HALT, ITYPE_I} instr_type_e;
  typedef enum logic [1:0] {FETCH, STALLED, HALTED} if_state_e;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_BRANCH, PC_JUMP} pc_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Unknown opcodes are treated as I-type so only HALT can stop fetch.
  function automatic instr_type_e decode_type(input logic [OPW-1:0] op);
    instr_type_e t;
    case (op)
      OP_R:                       t = ITYPE_R;
      OP_J, OP_JAL:               t = ITYPE_J;
      OP_HALT:                    t = ITYPE_HALT;
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: t = ITYPE_I;
      default:                    t = ITYPE_I;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_pc_unit.sv
// Program counter register with next-PC mux and +4 adder; PC is kept as a word address so bits [1:0] are always 0.
module if_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  pc_sel_e        pc_sel,
  input  logic [29:0]    branch_word,
  input  logic [3:0]     pc_region,
  input  logic [JFW-1:0] jump_addr,
  output logic [31:0]    pc,
  output logic [31:0]    pc_inc
);

  logic [29:0] pc_word_q;
  logic [29:0] pc_word_d;

  assign pc     = {pc_word_q, 2'b00};
  assign pc_inc = {pc_word_q + 30'd1, 2'b00};

  always_comb begin
    pc_word_d = pc_word_q;
    case (pc_sel)
      PC_INC:    pc_word_d = pc_word_q + 30'd1;
      PC_BRANCH: pc_word_d = branch_word;
      PC_JUMP:   pc_word_d = {pc_region, jump_addr};
      default:   pc_word_d = pc_word_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_word_q <= RESET_PC[31:2];
    else        pc_word_q <= pc_word_d;
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: FETCH/STALLED/HALTED control and IF/ID register.
// Optional fetch/stall performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [25:0]        jump_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction,
  output logic [31:0]        pc_plus4,
  output logic               if_valid,
  output logic               halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  if_state_e state_q, state_d;
  pc_sel_e   pc_sel;
  ifid_t     ifid_q, ifid_d;
  logic      halted_d;
  logic      fetch_en;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [1:0]  unused_target_lsbs;

  assign unused_target_lsbs = branch_target[1:0];

  if_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_sel      (pc_sel),
    .branch_word (branch_target[31:2]),
    .pc_region   (ifid_q.pc_plus4[31:28]),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .pc_inc      (pc_inc)
  );

  assign imem_addr   = IMEM_AW'(pc);
  assign instruction = ifid_q.instr;
  assign pc_plus4    = ifid_q.pc_plus4;
  assign if_valid    = ifid_q.valid;

  // Next state: redirect > stall > fetch (with HALT detection); HALTED ignores all inputs.
  always_comb begin
    state_d  = state_q;
    pc_sel   = PC_HOLD;
    ifid_d   = ifid_q;
    halted_d = halted;
    fetch_en = 1'b0;
    case (state_q)
      HALTED: begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
        halted_d     = 1'b1;
      end
      default: begin
        if (branch_taken || jump) begin
          pc_sel       = branch_taken ? PC_BRANCH : PC_JUMP;
          ifid_d.instr = NOP_INSTR;
          ifid_d.valid = 1'b0;
          state_d      = FETCH;
        end else if (stall) begin
          state_d = STALLED;
        end else begin
          pc_sel          = PC_INC;
          fetch_en        = 1'b1;
          ifid_d.instr    = imem_rdata;
          ifid_d.pc_plus4 = pc_inc;
          ifid_d.valid    = 1'b1;
          if (decode_type(imem_rdata[31:26]) == ITYPE_HALT) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ifid_q  <= '{instr: NOP_INSTR, pc_plus4: RESET_PC, valid: 1'b0};
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      halted  <= halted_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Counters stop by construction in HALTED: no fetches and no STALLED cycles occur there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (fetch_en)            fetch_count <= fetch_count + 32'd1;
      if (state_q == STALLED)  stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_fetch_en;
  assign unused_fetch_en = fetch_en;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a cycle-level behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_addr = 26'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;

  logic [31:0] m_pc, m_instr, m_ppc4;
  logic        m_valid, m_halted;

  int n_pass  = 0;
  int n_total = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_plus4      (pc_plus4),
    .if_valid      (if_valid),
    .halted        (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Instruction memory contents: fixed word at 0, hashed non-HALT words elsewhere, optional HALT slot.
  function automatic logic [31:0] imem_word(input logic [31:0] a, input logic hen, input logic [31:0] haddr);
    logic [31:0] w;
    if (hen && a == haddr) return 32'hFC00_0000;
    if (a == 32'h0) return 32'h2001_0005;
    w = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    if (w[31:26] == 6'h3F) w[26] = 1'b0;
    return w;
  endfunction

  always_comb imem_rdata = imem_word(imem_addr, halt_en, halt_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"},   imem_addr,   m_pc);
    check({tag, ".instruction"}, instruction, m_instr);
    check({tag, ".pc_plus4"},    pc_plus4,    m_ppc4);
    check({tag, ".if_valid"},    32'(if_valid), 32'(m_valid));
    check({tag, ".halted"},      32'(halted),   32'(m_halted));
  endtask

  // One clock of the reference fetch behaviour, using the inputs currently applied.
  task automatic model_step();
    logic [31:0] w;
    if (m_halted) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (branch_taken) begin
      m_pc    = branch_target & 32'hFFFF_FFFC;
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (jump) begin
      m_pc    = {m_ppc4[31:28], jump_addr, 2'b00};
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (!stall) begin
      w       = imem_word(m_pc, halt_en, halt_addr);
      m_instr = w;
      m_ppc4  = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      if (w[31:26] == 6'h3F) m_halted = 1'b1;
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic j, input logic [25:0] ja);
    stall = s; branch_taken = b; branch_target = t; jump = j; jump_addr = ja;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after a rising edge; releases reset on the following falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_ppc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    #2;
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #6;
    do_reset("reset0");

    tick("first");
    check("first_instr", instruction, 32'h2001_0005);
    check("first_ppc4",  pc_plus4,    32'h4);
    check("first_valid", 32'(if_valid), 32'h1);
    check("first_addr",  imem_addr,   32'h4);

    tick("fetch4");
    drive(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall_addr",  imem_addr,   32'h8);
      check("stall_instr", instruction, imem_word(32'h4, 1'b0, 32'h0));
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    tick("resume8");
    check("resume8_instr", instruction, imem_word(32'h8, 1'b0, 32'h0));
    tick("resume12");
    check("resume12_instr", instruction, imem_word(32'hC, 1'b0, 32'h0));

    drive(1'b0, 1'b1, 32'h1000_000C, 1'b0, 26'h0);
    tick("pre_jump_br");
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    tick("pre_jump_fetch");
    check("pre_jump_ppc4", pc_plus4, 32'h1000_0010);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 26'h40);
    tick("jump");
    check("jump_addr",   imem_addr,   32'h1000_0100);
    check("jump_bubble", 32'(if_valid), 32'h0);
    check("jump_nop",    instruction, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    tick("post_jump");

    drive(1'b1, 1'b1, 32'h0000_0200, 1'b0, 26'h0);
    tick("br_vs_stall");
    check("br_vs_stall_addr",  imem_addr, 32'h200);
    check("br_vs_stall_valid", 32'(if_valid), 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0307, 1'b1, 26'h3FF_FFFF);
    tick("br_over_jump");
    check("br_lsb_ignored", imem_addr, 32'h304);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    tick("post_br");

    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    tick("wrap_br");
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    tick("wrap");
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_ppc4", pc_plus4,  32'h0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(11) == 0, $urandom(),
            $urandom_range(15) == 0, 26'($urandom()));
      tick("rand");
    end

    drive(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    tick("pre_rst_stall");
    tick("pre_rst_stall2");
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    do_reset("reset_mid_stall");
    tick("after_rst_stall");
    check("after_rst_stall_instr", instruction, 32'h2001_0005);

    drive(1'b0, 1'b1, 32'h0000_0400, 1'b0, 26'h0);
    tick("halt_br");
    halt_en = 1'b1;
    halt_addr = 32'h0000_0404;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    tick("halt_pre");
    tick("halt_fetch");
    check("halt_instr",  instruction, 32'hFC00_0000);
    check("halt_valid",  32'(if_valid), 32'h1);
    check("halt_flag",   32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(1) == 1, $urandom_range(1) == 1, $urandom(),
            $urandom_range(1) == 1, 26'($urandom()));
      tick("halted");
      check("halted_pc",    imem_addr, 32'h408);
      check("halted_valid", 32'(if_valid), 32'h0);
    end

    halt_en = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    do_reset("reset_mid_halt");
    tick("after_rst_halt");
    check("after_rst_halt_instr", instruction, 32'h2001_0005);
    check("after_rst_halt_flag",  32'(halted), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
